// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store sequencer with MOC handshake, byte-lane steering and load extension
module mem_access_unit #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                CLK,
    input  logic                CLR,
    input  logic                start,
    input  logic                rw,
    input  logic [1:0]          size,
    input  logic                sign,
    input  logic [DATA_W-1:0]   addr_in,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    output logic                mem_en,
    output logic                mem_rw,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_moc
);
    localparam int LANES = DATA_W / 8;
    localparam int OFS_W = $clog2(LANES);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_err;
    logic [1:0]        r_size;
    logic [OFS_W-1:0]  r_ofs;
    logic              r_sign;

    logic [OFS_W-1:0]  w_ofs;
    logic [3:0]        w_bytes;
    logic              w_bad;
    logic [LANES-1:0]  w_be;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_shift;
    logic [DATA_W-1:0] w_lmask;
    logic              w_sbit;
    logic [DATA_W-1:0] w_load;

    function automatic logic [DATA_W-1:0] lane_mask(input logic [1:0] sz);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int i = 0; i < LANES; i++)
            if (i < (1 << sz)) m[8*i +: 8] = 8'hFF;
        return m;
    endfunction

    assign w_ofs   = addr_in[OFS_W-1:0];
    assign w_bytes = 4'd1 << size;
    assign w_bad   = (32'(w_bytes) > LANES) || ((32'(w_ofs) & (32'(w_bytes) - 1)) != 0);
    assign w_wdata = (wdata & lane_mask(size)) << {w_ofs, 3'b000};

    always_comb begin
        w_be = '0;
        for (int i = 0; i < LANES; i++)
            w_be[i] = (i >= int'(w_ofs)) && (i < int'(w_ofs) + int'(w_bytes));
    end

    // Load path works from the captured size/offset, not the live inputs.
    assign w_shift = mem_rdata >> {r_ofs, 3'b000};
    assign w_lmask = lane_mask(r_size);

    always_comb begin
        w_sbit = 1'b0;
        for (int i = 0; i < LANES; i++)
            if (i == (1 << r_size) - 1) w_sbit = w_shift[8*i+7];
    end

    assign w_load = (w_shift & w_lmask) | ((r_sign && w_sbit) ? ~w_lmask : '0);

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_err     <= 1'b0;
            r_size    <= '0;
            r_ofs     <= '0;
            r_sign    <= 1'b0;
            rdata     <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            mem_en    <= 1'b0;
            mem_rw    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_err <= 1'b0;
                    if (start) begin
                        if (w_bad) begin
                            r_err   <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            mem_addr  <= addr_in[ADDR_W-1:0];
                            mem_rw    <= rw;
                            mem_be    <= w_be;
                            mem_wdata <= w_wdata;
                            mem_en    <= 1'b1;
                            r_size    <= size;
                            r_ofs     <= w_ofs;
                            r_sign    <= sign;
                            r_cnt     <= '0;
                            r_state   <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_moc) begin
                        if (!mem_rw) rdata <= w_load;
                        mem_en  <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                            mem_en  <= 1'b0;
                            r_err   <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_err   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE);
    assign err  = r_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed and randomized checks of mem_access_unit against a byte-level model
module tb_mem_access_unit;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 8;
    localparam int TIMEOUT = 15;
    localparam int LANES   = DATA_W / 8;

    logic              CLK = 1'b0;
    logic              CLR = 1'b0;
    logic              start = 1'b0;
    logic              rw = 1'b0;
    logic [1:0]        size = '0;
    logic              sign = 1'b0;
    logic [DATA_W-1:0] addr_in = '0;
    logic [DATA_W-1:0] wdata = '0;
    logic [DATA_W-1:0] rdata;
    logic              busy, done, err;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [LANES-1:0]  mem_be;
    logic              mem_en, mem_rw;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              mem_moc = 1'b0;

    int n_vec  = 0;
    int n_fail = 0;
    logic [31:0] exp_rdata = '0;

    mem_access_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .CLR(CLR), .start(start), .rw(rw), .size(size), .sign(sign),
        .addr_in(addr_in), .wdata(wdata), .rdata(rdata), .busy(busy), .done(done),
        .err(err), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_en(mem_en), .mem_rw(mem_rw), .mem_rdata(mem_rdata), .mem_moc(mem_moc)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic scramble_inputs();
        rw      = 1'($urandom);
        size    = 2'($urandom);
        sign    = 1'($urandom);
        addr_in = $urandom;
        wdata   = $urandom;
    endtask

    // One request end to end; wait_i is the number of REQ edges with mem_moc low before MOC.
    task automatic access(input logic rw_i, input logic [1:0] size_i, input logic sign_i,
                          input logic [31:0] addr_i, input logic [31:0] wdata_i,
                          input logic [31:0] mdata_i, input int wait_i);
        int bytes, ofs;
        bit bad, fin;
        longint unsigned lm, ebe, ewd, val;
        bytes = 1 << size_i;
        ofs   = int'(addr_i % LANES);
        bad   = (bytes > LANES) || (ofs % bytes != 0);
        lm    = (64'd1 << (8 * bytes)) - 1;
        ebe   = ((64'd1 << bytes) - 1) << ofs;
        ewd   = ((longint'(wdata_i) & lm) << (8 * ofs)) & 64'hFFFF_FFFF;

        @(negedge CLK);
        start = 1'b1; rw = rw_i; size = size_i; sign = sign_i; addr_in = addr_i; wdata = wdata_i;
        @(negedge CLK);
        start = 1'b0;
        scramble_inputs();
        chk("busy_after_accept", 64'(busy), 64'd1);
        if (bad) begin
            chk("reject_done", 64'(done), 64'd1);
            chk("reject_err", 64'(err), 64'd1);
            chk("reject_mem_en", 64'(mem_en), 64'd0);
        end else begin
            chk("mem_en", 64'(mem_en), 64'd1);
            chk("mem_be", 64'(mem_be), ebe);
            chk("mem_addr", 64'(mem_addr), 64'(addr_i[ADDR_W-1:0]));
            chk("mem_rw", 64'(mem_rw), 64'(rw_i));
            if (rw_i) chk("mem_wdata", 64'(mem_wdata), ewd);
            fin = 1'b0;
            for (int n = 1; n <= TIMEOUT && !fin; n++) begin
                if (n - 1 == wait_i) begin
                    mem_moc = 1'b1; mem_rdata = mdata_i;
                end else begin
                    mem_moc = 1'b0; mem_rdata = $urandom;
                end
                @(negedge CLK);
                if (mem_moc) begin
                    mem_moc = 1'b0;
                    fin = 1'b1;
                    if (!rw_i) begin
                        val = (longint'(mdata_i) >> (8 * ofs)) & lm;
                        if (sign_i && val >= (64'd1 << (8 * bytes - 1)))
                            val = val + ((64'd1 << 32) - (64'd1 << (8 * bytes)));
                        exp_rdata = val[31:0];
                    end
                    chk("done", 64'(done), 64'd1);
                    chk("err_ok", 64'(err), 64'd0);
                    chk("mem_en_done", 64'(mem_en), 64'd0);
                end else if (n == TIMEOUT) begin
                    fin = 1'b1;
                    chk("timeout_done", 64'(done), 64'd1);
                    chk("timeout_err", 64'(err), 64'd1);
                    chk("timeout_mem_en", 64'(mem_en), 64'd0);
                end else begin
                    chk("req_no_done", 64'(done), 64'd0);
                    chk("req_mem_en", 64'(mem_en), 64'd1);
                end
            end
        end
        chk("rdata", 64'(rdata), 64'(exp_rdata));
        @(negedge CLK);
        chk("idle_done", 64'(done), 64'd0);
        chk("idle_err", 64'(err), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_mem_en", 64'(mem_en), 64'd0);
    endtask

    initial begin
        #1;
        chk("rst_rdata", 64'(rdata), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_mem_en", 64'(mem_en), 64'd0);
        chk("rst_mem_rw", 64'(mem_rw), 64'd0);
        chk("rst_mem_be", 64'(mem_be), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        @(negedge CLK);
        CLR = 1'b1;

        // Directed cases
        access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 3);
        access(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 32'h80123456, 0);
        access(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 32'h80123456, 1);
        access(1'b1, 2'd1, 1'b0, 32'h22, 32'h1234ABCD, 32'h0, 2);
        access(1'b0, 2'd1, 1'b0, 32'h21, 32'h0, 32'h0, 0);
        access(1'b0, 2'd3, 1'b0, 32'h20, 32'h0, 32'h0, 0);
        access(1'b0, 2'd1, 1'b1, 32'h42, 32'h0, 32'h8001_7FFF, TIMEOUT + 5);
        access(1'b0, 2'd1, 1'b1, 32'h42, 32'h0, 32'h8001_7FFF, TIMEOUT - 1);

        // Stray MOC while idle
        @(negedge CLK);
        mem_moc = 1'b1;
        @(negedge CLK);
        mem_moc = 1'b0;
        chk("stray_moc_busy", 64'(busy), 64'd0);
        chk("stray_moc_done", 64'(done), 64'd0);

        // Start during busy is ignored, then reset mid-request
        @(negedge CLK);
        start = 1'b1; rw = 1'b0; size = 2'd2; sign = 1'b0; addr_in = 32'h04;
        @(negedge CLK);
        start = 1'b1; size = 2'd0; addr_in = 32'h07;
        @(negedge CLK);
        start = 1'b0;
        chk("busy_start_ignored_be", 64'(mem_be), 64'hF);
        chk("busy_start_ignored_en", 64'(mem_en), 64'd1);
        chk("busy_start_ignored_done", 64'(done), 64'd0);
        CLR = 1'b0;
        #1;
        chk("rst_mid_mem_en", 64'(mem_en), 64'd0);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_rdata", 64'(rdata), 64'd0);
        exp_rdata = '0;
        @(negedge CLK);
        CLR = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("post_rst_done", 64'(done), 64'd0);
            chk("post_rst_busy", 64'(busy), 64'd0);
        end

        // Randomized accesses
        for (int i = 0; i < 150; i++) begin
            access(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
                   int'($urandom_range(0, TIMEOUT + 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised memory access sequencer replacing the fixed 8-bit MAR / 32-bit MDR pair in the datapath. It accepts one load/store request from the control unit, drives the memory port through a request/MOC (memory-operation-complete) handshake, and performs byte-lane steering on stores and lane extraction with zero/sign extension on loads. It also flags misaligned, oversized and timed-out accesses.

## Interface
- DATA_W, 32: data width in bits; legal values 16, 32, 64; LANES = DATA_W/8, OFS_W = log2(LANES)
- ADDR_W, 8: memory address width; mem_addr = addr_in[ADDR_W-1:0]
- TIMEOUT, 15: maximum REQ cycles without mem_moc before error; must be ≥ 1

Ports:
- CLK  in  1  clock, rising edge
- CLR  in  1  asynchronous active-low reset
- start  in  1  request strobe; sampled only in IDLE
- rw  in  1  0 = load, 1 = store
- size  in  2  access size = 2^size bytes
- sign  in  1  load sign-extend enable
- addr_in  in  DATA_W  byte address, from ALU
- wdata  in  DATA_W  store data, right-aligned
- rdata  out  DATA_W  load result (MDR); holds until next load completes
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse, coincident with done, on a failed access
- mem_addr  out  ADDR_W  registered address
- mem_wdata  out  DATA_W  lane-steered store data
- mem_be  out  LANES  byte enables
- mem_en  out  1  request active
- mem_rw  out  1  copy of rw for the active request
- mem_moc  in  1  memory operation complete

## Operation
- States:
  - IDLE: waits for start.
  - REQ: request in flight.
  - DONE: one cycle; asserts done.
- IDLE with start=1 at an edge:
  - Error case: bytes = 2^size > LANES, or addr_in[OFS_W-1:0] not a multiple of the byte count. Go to DONE with err=1. No memory request is issued and mem_en stays 0.
  - Otherwise: register mem_addr, mem_rw, mem_be and mem_wdata; set mem_en=1; clear the wait counter; go to REQ.
- Byte enables: mem_be has `bytes` consecutive ones starting at lane ofs = addr_in[OFS_W-1:0]. Lane 0 is bits [7:0] (little-endian).
- Store data: mem_wdata = (wdata masked to 8·bytes bits) << 8·ofs. Lanes that are not enabled are 0.
- REQ with mem_moc=1 at an edge:
  - Load: rdata = selected lanes shifted right by 8·ofs, then zero-extended, or sign-extended from bit 8·bytes−1 when sign=1.
  - Load and store: mem_en→0, go to DONE.
- REQ with mem_moc=0: the counter increments. On the edge where the counter reaches TIMEOUT: mem_en→0, err=1, go to DONE, rdata unchanged.
- DONE: done=1, and err=1 if flagged. Next edge goes to IDLE and clears done/err.
- start outside IDLE is ignored; no queuing.
- Inputs rw, size, sign, addr_in and wdata are captured at the accepting edge; later changes have no effect.

## Timing
- Reset (CLR=0, asynchronous):
  - state=IDLE.
  - rdata, mem_addr, mem_wdata, mem_be = 0.
  - mem_en, mem_rw, busy, done, err = 0.
  - Counter = 0.
  - Applies mid-request: mem_en drops immediately and no done is produced.
- All outputs are registered or decoded from state; none is combinational from inputs.
- Best case: start at edge k, mem_moc=1 at edge k+1, done high during cycle k+2. The next start is accepted at edge k+3.
- Error-reject path: start at edge k, done+err high during cycle k+1.
- Timeout path: done+err high in the cycle following the TIMEOUT-th REQ cycle with mem_moc low.
- mem_moc is sampled only in REQ; a stray mem_moc in IDLE/DONE is ignored.
- busy is high for the entire interval from the cycle after acceptance through DONE.

## Test plan
- Word load (DATA_W=32): addr_in=0x10, size=2. Memory returns 0xDEADBEEF with mem_moc after 3 wait cycles → mem_be=1111, rdata=0xDEADBEEF, done one cycle, err=0.
- Signed byte load: addr_in=0x13, size=0, sign=1, memory data 0x80xxxxxx → mem_be=1000, rdata=0xFFFFFF80. Repeat with sign=0 → rdata=0x00000080.
- Halfword store: addr_in=0x22, wdata=0x1234ABCD, size=1 → mem_be=1100, mem_wdata=0xABCD0000, mem_rw=1.
- Misaligned/oversize rejection:
  - addr_in=0x21, size=1 → done+err in the next cycle, mem_en never asserted.
  - size=3 with DATA_W=32 → same result.
- Timeout: TIMEOUT=15, mem_moc held 0 → err+done after 15 REQ cycles, mem_en low, rdata unchanged.
- Reset mid-REQ: assert CLR=0 two cycles after start → mem_en=0 immediately; after release busy=0, no done pulse. A start pulse during busy is ignored.
